sr_mul_seq: RTL and testbench
=============================

SR_MUL_SEQ -- requirements
Module: sr_mul_seq

Interface
REQ-001 The block SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 Port list (name  direction  width  meaning), one per line:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request a multiply
- op_a  in  32  multiplicand, sampled on the accepted start
- op_b  in  32  multiplier, sampled on the accepted start
- busy  out  1  sequencer owns the shared ALU
- done  out  1  one-cycle pulse, result valid
- result  out  32  low 32 bits of op_a*op_b
- cpu_srcA  in  32  CPU ALU operand A
- cpu_srcB  in  32  CPU ALU operand B
- cpu_oper  in  4  CPU ALU operation code
- alu_srcA  out  32  to shared ALU srcA
- alu_srcB  out  32  to shared ALU srcB
- alu_oper  out  4  to shared ALU oper
- alu_result  in  32  from shared ALU result
REQ-003 Operation codes SHALL use the `ALU_ADD macro from sr_cpu.vh; no parameters.

Function
REQ-004 FSM states SHALL be IDLE, RUN and DONE.
REQ-005 Start SHALL be accepted only when start=1 and state is IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands or latency.
REQ-006 On acceptance at cycle T: acc<=0, mcand<=op_a, mplier<=op_b, count<=0, state<=RUN.
REQ-007 Each RUN cycle: alu_srcA=acc, alu_srcB=mcand, alu_oper=`ALU_ADD; if mplier[0]=1 then acc<=alu_result; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
REQ-008 RUN SHALL go to DONE after the cycle with count=31, i.e. RUN spans T+1..T+32 and done=1 at T+33.
REQ-009 In DONE: done=1 for exactly one cycle; state<=IDLE unless a new start is accepted (then RUN).
REQ-010 result SHALL equal acc, hold its value from DONE until the next accepted start completes, and wrap modulo 2^32 (low product bits only, signedness-independent).
REQ-011 busy SHALL be 1 exactly in RUN.
REQ-012 In IDLE and DONE, alu_srcA/alu_srcB/alu_oper SHALL combinationally equal cpu_srcA/cpu_srcB/cpu_oper.
REQ-013 While busy=1, the CPU SHALL stall; the block does not buffer CPU ALU requests.

Reset
REQ-014 On rst=1 at a clock edge: state<=IDLE, busy=0, done=0, result=0, count=0; this applies in any state.
REQ-015 A reset during RUN SHALL abandon the operation, with no done pulse.
REQ-016 rst SHALL take priority over a simultaneous start.

Configuration
REQ-017 Macro SR_MUL_EARLY_EXIT_EN defined: RUN SHALL also go to DONE after any RUN cycle in which mplier[31:1]=0, with an identical result.
REQ-018 Macro undefined: latency SHALL be fixed at 33 cycles from start to done.

Verification
REQ-019 op_a=6, op_b=7 at T, macro off -> busy T+1..T+32, done=1 and result=42 at T+33.
REQ-020 op_a=op_b=0xFFFFFFFF -> result=0x00000001 at done.
REQ-021 start with op_a=3, op_b=3 at T+5 during a running 6x7 -> ignored; result=42 at T+33; no second done.
REQ-022 rst at T+10 of a running op -> IDLE next cycle, busy=0, result=0, no done pulse.
REQ-023 Idle, cpu_srcA=5, cpu_srcB=9, cpu_oper=`ALU_ADD -> alu ports equal the CPU inputs in the same cycle; during RUN they show acc/mcand/`ALU_ADD.
REQ-024 SR_MUL_EARLY_EXIT_EN defined: op_b=5, op_a=4 -> RUN T+1..T+3, done at T+4, result=20; op_b=0 -> done at T+2, result=0.

Source files
------------

// File: rtl/sr_mul_seq.sv
// sr_mul_seq: 32-cycle shift-add multiplier that borrows the CPU's shared ALU while running.
// Define SR_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
module sr_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  input  logic [31:0] cpu_srcA,
  input  logic [31:0] cpu_srcB,
  input  logic [3:0]  cpu_oper,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [3:0]  alu_oper,
  input  logic [31:0] alu_result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, res_q, res_d;
  logic [4:0]  count_q, count_d;
  logic        run, last;
  assign run = state_q == RUN;
`ifdef SR_MUL_EARLY_EXIT_EN
  assign last = count_q == 5'd31 || mplier_q[31:1] == 31'd0;
`else
  assign last = count_q == 5'd31;
`endif
  assign busy     = run;
  assign done     = state_q == DONE;
  assign result   = res_q;
  assign alu_srcA = run ? acc_q : cpu_srcA;
  assign alu_srcB = run ? mcand_q : cpu_srcB;
  assign alu_oper = run ? `ALU_ADD : cpu_oper;
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    res_d    = res_q;
    if (start && !run) begin
      state_d  = RUN;
      acc_d    = 32'd0;
      mcand_d  = op_a;
      mplier_d = op_b;
      count_d  = 5'd0;
    end else if (run) begin
      acc_d    = mplier_q[0] ? alu_result : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 5'd1;
      state_d  = last ? DONE : RUN;
      res_d    = last ? acc_d : res_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      count_q  <= 5'd0;
      res_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      res_q    <= res_d;
    end
  end
endmodule

// File: tb/tb_sr_mul_seq.sv
// tb_sr_mul_seq: directed vector table plus hand sequences for sr_mul_seq.
`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
module tb_sr_mul_seq;
  logic        clk = 0, rst, start;
  logic [31:0] op_a, op_b, result, cpu_srcA, cpu_srcB, alu_srcA, alu_srcB, alu_result;
  logic [3:0]  cpu_oper, alu_oper;
  logic        busy, done;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  sr_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .cpu_srcA(cpu_srcA), .cpu_srcB(cpu_srcB), .cpu_oper(cpu_oper),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_oper(alu_oper),
    .alu_result(alu_result)
  );
  assign alu_result = (alu_oper == `ALU_ADD) ? alu_srcA + alu_srcB : alu_srcA ^ alu_srcB;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic int exp_lat(input logic [31:0] b);
    int runs;
    runs = 32;
`ifdef SR_MUL_EARLY_EXIT_EN
    runs = 1;
    for (int i = 0; i < 32; i++) if (b[i]) runs = i + 1;
`endif
    return runs + 1;
  endfunction
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    int cyc, bad_busy;
    cyc = 0;
    bad_busy = 0;
    @(negedge clk);
    start = 1; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 0;
    for (int i = 1; i <= 40 && cyc == 0; i++) begin
      @(negedge clk);
      if (done) cyc = i;
      else if (!busy) bad_busy++;
    end
    chk("latency", cyc, exp_lat(b));
    chk("result", result, p);
    chk("busy_in_run", bad_busy, 0);
    chk("busy_at_done", {31'd0, busy}, 0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("result_hold", result, p);
  endtask
  initial begin
    int first_done, n_done;
    vecs[0] = '{32'd6, 32'd7, 32'd42};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[2] = '{32'h00010000, 32'h00010000, 32'h00000000};
    vecs[3] = '{32'h12345678, 32'h00000000, 32'h00000000};
    vecs[4] = '{32'h80000000, 32'd3, 32'h80000000};
    vecs[5] = '{32'h00001234, 32'h00005678, 32'h06260060};
    vecs[6] = '{32'd4, 32'd5, 32'd20};
    vecs[7] = '{32'd3, 32'h55555555, 32'hFFFFFFFF};
    rst = 1; start = 0; op_a = 0; op_b = 0;
    cpu_srcA = 32'd5; cpu_srcB = 32'd9; cpu_oper = `ALU_ADD;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_result", result, 0);
    chk("idle_srcA", alu_srcA, 32'd5);
    chk("idle_srcB", alu_srcB, 32'd9);
    chk("idle_oper", {28'd0, alu_oper}, {28'd0, `ALU_ADD});
    cpu_oper = 4'h3;
    #1 chk("idle_oper_follow", {28'd0, alu_oper}, 32'h3);
    for (int v = 0; v < 8; v++) run_mul(vecs[v].a, vecs[v].b, vecs[v].p);
    // start during RUN must not disturb the running operation
    cpu_srcA = 32'h0000AAAA; cpu_srcB = 32'h0000BBBB;
    @(negedge clk);
    start = 1; op_a = 32'd6; op_b = 32'h80000007;
    @(posedge clk);
    #1 start = 0;
    first_done = 0; n_done = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("run_srcA", alu_srcA, 32'd0);
        chk("run_srcB", alu_srcB, 32'd6);
        chk("run_oper", {28'd0, alu_oper}, {28'd0, `ALU_ADD});
      end
      if (i == 2) chk("run_srcB_shift", alu_srcB, 32'd12);
      if (i == 5) begin start = 1; op_a = 32'd3; op_b = 32'd3; end
      if (i == 6) start = 0;
      if (done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = i;
          chk("ignored_start_result", result, 32'd42);
        end
      end
    end
    chk("ignored_start_latency", first_done, 33);
    chk("ignored_start_ndone", n_done, 1);
    // reset mid-run abandons the operation
    @(negedge clk);
    start = 1; op_a = 32'd6; op_b = 32'h80000007;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_run_busy", {31'd0, busy}, 0);
    chk("rst_run_result", result, 0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("rst_run_no_done", n_done, 0);
    // reset wins over a simultaneous start
    @(negedge clk);
    rst = 1; start = 1; op_a = 32'd2; op_b = 32'd2;
    @(posedge clk);
    #1 rst = 0; start = 0;
    @(negedge clk);
    chk("rst_prio_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("rst_prio_busy2", {31'd0, busy}, 0);
    chk("rst_prio_result", result, 0);
    run_mul(32'd6, 32'd7, 32'd42);
`ifdef SR_MUL_EARLY_EXIT_EN
    run_mul(32'd4, 32'd0, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
